// File: rtl/dmem_responder_if.sv
// LSU-to-data-memory port: request fields from the LSU, completion and busy back from the responder.
// A request is taken on a rising edge where read_en|write_en is high and mem_busy_o is low; dcache_valid_o marks completion.
interface dmem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr_i;
    logic              mem_read_en_i;
    logic              mem_write_en_i;
    logic [DATA_W-1:0] mem_write_data_i;
    logic [DATA_W-1:0] mem_read_data_o;
    logic              dcache_valid_o;
    logic              mem_busy_o;
    logic              addr_err_o;

    modport master (
        output mem_addr_i, mem_read_en_i, mem_write_en_i, mem_write_data_i,
        input  mem_read_data_o, dcache_valid_o, mem_busy_o, addr_err_o
    );

    modport slave (
        input  mem_addr_i, mem_read_en_i, mem_write_en_i, mem_write_data_i,
        output mem_read_data_o, dcache_valid_o, mem_busy_o, addr_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one LSU access at a time on a word RAM, completing LAT cycles after acceptance.
// FSM state is exported on dbg_state_o (0 IDLE, 1 WAIT, 2 RESP).
module dmem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int LAT    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus,
    output logic [1:0]       dbg_state_o
);

    localparam int IDX_W  = ADDR_W - 1;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT > 1) ? (LAT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [RAM_AW-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;
    logic              r_in_range;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_ram [DEPTH];

    logic [IDX_W-1:0]  w_word;
    logic              w_req;
    logic              w_in_range;
    logic              w_accept;
    logic              w_access;
    logic [RAM_AW-1:0] w_acc_idx;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_acc_wr;
    logic              w_acc_in_range;
    logic              w_unused_addr0;

    assign w_word         = bus.mem_addr_i[ADDR_W-1:1];
    assign w_unused_addr0 = bus.mem_addr_i[0];
    assign w_req          = bus.mem_read_en_i | bus.mem_write_en_i;
    assign w_in_range     = (64'(w_word) < 64'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE, S_RESP: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (LAT > 1) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The access happens on the edge entering RESP. With LAT=1 that is the accept edge
    // itself, so the live request is used instead of the (not yet loaded) latch.
    always_comb begin
        w_access = (w_state_nxt == S_RESP);
        if (r_state == S_WAIT) begin
            w_acc_idx      = r_idx;
            w_acc_wdata    = r_wdata;
            w_acc_wr       = r_is_wr;
            w_acc_in_range = r_in_range;
        end else begin
            w_acc_idx      = w_word[RAM_AW-1:0];
            w_acc_wdata    = bus.mem_write_data_i;
            w_acc_wr       = bus.mem_write_en_i;
            w_acc_in_range = w_in_range;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_in_range <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx      <= w_word[RAM_AW-1:0];
                r_wdata    <= bus.mem_write_data_i;
                r_is_wr    <= bus.mem_write_en_i;
                r_in_range <= w_in_range;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
        end else if (w_access && !w_acc_wr) begin
            r_rdata <= w_acc_in_range ? r_ram[w_acc_idx] : '0;
        end
    end

    // RAM contents survive reset; reset only blocks a write that was still in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_access && w_acc_wr && w_acc_in_range) begin
            r_ram[w_acc_idx] <= w_acc_wdata;
        end
    end

    assign bus.mem_read_data_o = r_rdata;
    assign bus.dcache_valid_o  = (r_state == S_RESP);
    assign bus.mem_busy_o      = (r_state == S_WAIT);
    assign bus.addr_err_o      = (r_state == S_RESP) && !r_in_range;
    assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LAT=2 and a LAT=1 instance share one stimulus bus selected by sel.
// A reference RAM model predicts each completion (data, error flag, cycle) into a scoreboard queue.
module tb_dmem_responder;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int EXP_W = 16 + 1 + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          sel;
    logic [AW-1:0] req_addr;
    logic          req_rd;
    logic          req_wr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    dbg_l2;
    logic [1:0]    dbg_l1;

    dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if_l2 ();
    dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if_l1 ();

    assign if_l2.mem_addr_i       = req_addr;
    assign if_l2.mem_read_en_i    = req_rd & ~sel;
    assign if_l2.mem_write_en_i   = req_wr & ~sel;
    assign if_l2.mem_write_data_i = req_wdata;
    assign if_l1.mem_addr_i       = req_addr;
    assign if_l1.mem_read_en_i    = req_rd & sel;
    assign if_l1.mem_write_en_i   = req_wr & sel;
    assign if_l1.mem_write_data_i = req_wdata;

    dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LAT(2)) u_dut_l2 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .bus         (if_l2.slave),
        .dbg_state_o (dbg_l2)
    );

    dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LAT(1)) u_dut_l1 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .bus         (if_l1.slave),
        .dbg_state_o (dbg_l1)
    );

    logic          w_valid, w_busy, w_err;
    logic [DW-1:0] w_rdata;
    assign w_valid = sel ? if_l1.dcache_valid_o  : if_l2.dcache_valid_o;
    assign w_busy  = sel ? if_l1.mem_busy_o      : if_l2.mem_busy_o;
    assign w_err   = sel ? if_l1.addr_err_o      : if_l2.addr_err_o;
    assign w_rdata = sel ? if_l1.mem_read_data_o : if_l2.mem_read_data_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [DW-1:0]    mdl_l2 [DEPTH];
    logic [DW-1:0]    mdl_l1 [DEPTH];
    logic             wrt_l2 [DEPTH];
    logic             wrt_l1 [DEPTH];
    logic [DW-1:0]    last_l2;
    logic [DW-1:0]    last_l1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every completion must match the oldest prediction, including its cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_busy) busy_cnt++;
            if (w_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_valid", 64'(w_valid), 64'(0));
                end else begin
                    logic [EXP_W-1:0] e;
                    e = exp_q.pop_front();
                    check_val("rdata", 64'(w_rdata), 64'(e[DW-1:0]));
                    check_val("addr_err", 64'(w_err), 64'(e[DW]));
                    check_val("latency", 64'(cyc[15:0]), 64'(e[EXP_W-1:DW+1]));
                end
            end else if (w_err) begin
                check_val("err_without_valid", 64'(w_err), 64'(0));
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        int            waited;
        int            lat;
        logic [AW-2:0] word;
        logic          inr;
        logic [7:0]    idx;
        logic [DW-1:0] d;
        @(negedge clk);
        req_addr  = addr;
        req_rd    = rd;
        req_wr    = wr;
        req_wdata = data;
        waited = 0;
        while (w_busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (w_busy) begin
            check_val("accept_timeout", 64'(w_busy), 64'(0));
            req_rd = 1'b0;
            req_wr = 1'b0;
            return;
        end
        lat  = sel ? 1 : 2;
        word = addr[AW-1:1];
        inr  = (int'(word) < DEPTH);
        idx  = word[7:0];
        if (wr) begin
            d = sel ? last_l1 : last_l2;
            if (inr) begin
                if (sel) begin mdl_l1[idx] = data; wrt_l1[idx] = 1'b1; end
                else     begin mdl_l2[idx] = data; wrt_l2[idx] = 1'b1; end
            end
        end else begin
            d = inr ? (sel ? mdl_l1[idx] : mdl_l2[idx]) : '0;
            if (sel) last_l1 = d; else last_l2 = d;
        end
        exp_q.push_back({16'(cyc + lat), ~inr, d});
        @(posedge clk);
        #1;
        req_rd = 1'b0;
        req_wr = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            check_val("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        last_l2 = '0;
        last_l1 = '0;
    endtask

    task automatic directed_seq();
        do_req(1'b0, 1'b1, 16'h0040, 16'h4000);
        drain();
        do_req(1'b1, 1'b0, 16'h0040, 16'h0000);
        drain();
        // read presented while the write is completing: no idle gap
        do_req(1'b0, 1'b1, 16'h0006, 16'h1221);
        do_req(1'b1, 1'b0, 16'h0006, 16'h0000);
        drain();
        do_req(1'b0, 1'b1, 16'h0000, 16'h5A5A);
        do_req(1'b1, 1'b0, 16'h8000, 16'h0000);
        do_req(1'b0, 1'b1, 16'h8000, 16'hDEAD);
        do_req(1'b1, 1'b0, 16'h0000, 16'h0000);
        drain();
        do_req(1'b1, 1'b1, 16'h0010, 16'hFF0F);
        do_req(1'b1, 1'b0, 16'h0011, 16'h0000);
        drain();
    endtask

    task automatic random_seq(input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            logic          rd;
            logic [7:0]    w;
            rd = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) begin
                a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            end else begin
                a = 16'($urandom_range(0, 15) * 2 + $urandom_range(0, 1));
                w = a[8:1];
                if (rd && !(sel ? wrt_l1[w] : wrt_l2[w])) rd = 1'b0;
            end
            do_req(rd, ~rd, a, 16'($urandom_range(0, 16'hFFFF)));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_addr  = '0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wrt_l2[i] = 1'b0;
            wrt_l1[i] = 1'b0;
            mdl_l2[i] = '0;
            mdl_l1[i] = '0;
        end
        apply_reset();
        check_val("rst_rdata_l2", 64'(if_l2.mem_read_data_o), 64'(0));
        check_val("rst_valid_l2", 64'(if_l2.dcache_valid_o), 64'(0));
        check_val("rst_busy_l2", 64'(if_l2.mem_busy_o), 64'(0));
        check_val("rst_err_l2", 64'(if_l2.addr_err_o), 64'(0));
        check_val("rst_state_l2", 64'(dbg_l2), 64'(0));
        check_val("rst_rdata_l1", 64'(if_l1.mem_read_data_o), 64'(0));
        check_val("rst_state_l1", 64'(dbg_l1), 64'(0));

        // LAT=2: one WAIT cycle per access
        sel = 1'b0;
        busy_cnt = 0;
        do_req(1'b0, 1'b1, 16'h0040, 16'h4000);
        do_req(1'b1, 1'b0, 16'h0040, 16'h0000);
        drain();
        check_val("busy_cycles_l2", 64'(busy_cnt), 64'(2));
        directed_seq();

        // reset while a write sits in WAIT must drop it
        do_req(1'b0, 1'b1, 16'h0020, 16'h1357);
        drain();
        @(negedge clk);
        req_addr = 16'h0020; req_wdata = 16'h0099; req_wr = 1'b1;
        @(posedge clk);
        #1;
        req_wr = 1'b0;
        @(negedge clk);
        check_val("wait_busy", 64'(if_l2.mem_busy_o), 64'(1));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("abort_rdata", 64'(if_l2.mem_read_data_o), 64'(0));
        rst_n   = 1'b1;
        last_l2 = '0;
        last_l1 = '0;
        do_req(1'b1, 1'b0, 16'h0020, 16'h0000);
        drain();
        random_seq(30);

        // LAT=1: completes the cycle after acceptance, never busy
        sel = 1'b1;
        repeat (2) @(negedge clk);
        busy_cnt = 0;
        directed_seq();
        random_seq(30);
        check_val("busy_cycles_l1", 64'(busy_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the LSU memory port.
- Accepts one read or write request at a time from the LSU (address, read/write enables, write data).
- Performs the access on an internal word-organised RAM after a programmable latency, then returns read data and a one-cycle completion pulse.
- Drives the busy/stall indication the LSU uses to hold its request.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, LSU byte-address width.
- DEPTH, 256, number of words in the RAM; power of two, at least 2.
- LAT, 2, cycles from request acceptance to completion pulse; at least 1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- mem_addr_i  in  ADDR_W  byte address from the LSU.
- mem_read_en_i  in  1  read request.
- mem_write_en_i  in  1  write request.
- mem_write_data_i  in  DATA_W  store data.
- mem_read_data_o  out  DATA_W  load data; valid when dcache_valid_o=1.
- dcache_valid_o  out  1  one-cycle completion pulse, for both reads and writes.
- mem_busy_o  out  1  request cannot be accepted this cycle; the LSU holds its request.
- addr_err_o  out  1  one-cycle pulse with dcache_valid_o when the completed access was out of range.

Behaviour:
- Reset (rst_i=0 at an edge): state IDLE, counter 0, mem_read_data_o=0, dcache_valid_o=0, mem_busy_o=0, addr_err_o=0, latched request cleared.
- Reset does not clear RAM contents.
- Reset mid-access aborts the access: a pending write is not performed and no valid pulse is issued.
- Word index = mem_addr_i[ADDR_W-1:1]; bit 0 is ignored.
- In range when the word index < DEPTH; otherwise out of range.
- States:
  - IDLE: mem_busy_o=0. A request (read_en or write_en) is accepted at the edge and latches addr, data, op, and range flag. Next state is WAIT with cnt=LAT-1 if LAT>1, else RESP.
  - WAIT: mem_busy_o=1. cnt decrements each cycle; when cnt==1 the next state is RESP. Inputs are ignored.
  - RESP: dcache_valid_o=1 for exactly this cycle; mem_busy_o=0.
    - A new request may be accepted in this cycle and follows the same transition as from IDLE.
    - Otherwise the next state is IDLE.
- Latency: request accepted at edge N, so dcache_valid_o is high in the cycle after edge N+LAT-1. Sustained throughput is one access per LAT cycles.
- Access is performed at the edge entering RESP.
  - Write: RAM[idx] <= latched data, but only if in range.
  - Read: mem_read_data_o <= RAM[idx] if in range, else 0.
  - A write: mem_read_data_o holds its previous value.
- A read accepted in the RESP cycle of a write to the same word returns the new data.
- read_en and write_en both high: treated as a write; the read is dropped.
- Out of range: the write is dropped, the read returns 0, and addr_err_o pulses with dcache_valid_o.
- mem_read_data_o holds its value until the next read completes.
- Requests presented while mem_busy_o=1 are ignored; the requester holds them.

Test Plan:
- Reset with rst_i=0 for 2 cycles, then release → all outputs 0, state IDLE, mem_busy_o=0.
- Write 0x4000 to addr 0x0040 (LAT=2), then read 0x0040 → write valid pulse 2 cycles after acceptance; read returns 0x4000 with dcache_valid_o high for exactly 1 cycle; mem_busy_o high for 1 cycle per access.
- Write 0x1221 to 0x0006; in its RESP cycle present a read of 0x0006 → read accepted with no idle gap; returns 0x1221; two valid pulses 2 cycles apart.
- Read addr 0x8000 (word 0x4000 ≥ DEPTH) → mem_read_data_o=0, addr_err_o and dcache_valid_o pulse together. Write 0xDEAD to 0x8000 → no RAM change; reading 0x0000 returns its prior value.
- read_en=write_en=1 at 0x0010 with data 0xFF0F → treated as a write; a later read of 0x0010 returns 0xFF0F.
- Write 0x0099 to 0x0020; assert reset during WAIT → no valid pulse; a later read of 0x0020 returns the pre-write contents.
- Repeat the latency checks with LAT=1: valid appears in the cycle immediately after acceptance; mem_busy_o is never asserted.
